grf_wb_arbiter: RTL and testbench



---
 rtl/grf_wb_arbiter_if.sv | 41 ++++
 rtl/grf_wb_arbiter.sv | 111 +++++++++++
 tb/tb_grf_wb_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/grf_wb_arbiter_if.sv
// rtl/grf_wb_arbiter_if.sv - GRF write-back arbiter bus bundle
interface grf_wb_arbiter_if;
   logic        P_Valid;
   logic [4:0]  P_Reg;
   logic [31:0] P_Data;
   logic [31:0] P_PC;
   logic        M_Valid;
   logic        M_Ready;
   logic [4:0]  M_Reg;
   logic [31:0] M_Data;
   logic [31:0] M_PC;
   logic        Pend_Issue;
   logic [4:0]  Pend_Reg;
   logic [4:0]  Query_Rs;
   logic [4:0]  Query_Rt;
   logic        Busy_Rs;
   logic        Busy_Rt;
   logic        Stall_Req;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic [31:0] WPC;

   // Arbiter side
   modport slave (
      input  P_Valid, P_Reg, P_Data, P_PC,
      input  M_Valid, M_Reg, M_Data, M_PC,
      input  Pend_Issue, Pend_Reg, Query_Rs, Query_Rt,
      output M_Ready, Busy_Rs, Busy_Rt, Stall_Req,
      output RegWrite, WriteReg, WriteData, WPC
   );

   // Pipeline / MDU / GRF side
   modport master (
      output P_Valid, P_Reg, P_Data, P_PC,
      output M_Valid, M_Reg, M_Data, M_PC,
      output Pend_Issue, Pend_Reg, Query_Rs, Query_Rt,
      input  M_Ready, Busy_Rs, Busy_Rt, Stall_Req,
      input  RegWrite, WriteReg, WriteData, WPC
   );
endinterface

// File: rtl/grf_wb_arbiter.sv
// rtl/grf_wb_arbiter.sv - GRF write-port arbiter with MDU result queue and pending scoreboard
module grf_wb_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic            Clock,
   input logic            Reset,
   grf_wb_arbiter_if.slave Bus
);
   localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CntW = $clog2(DEPTH) + 1;

   logic [4:0]      qReg  [DEPTH];
   logic [31:0]     qData [DEPTH];
   logic [31:0]     qPc   [DEPTH];
   logic [PtrW-1:0] rdPtr;
   logic [PtrW-1:0] wrPtr;
   logic [CntW-1:0] qCount;
   logic [31:0]     pending;
   logic [3:0]      starveCount;

   logic        qEmpty;
   logic        qFull;
   logic        pipeOwns;
   logic        doPop;
   logic        doPush;
   logic [31:0] setMask;
   logic [31:0] clearMask;

   assign qEmpty = (qCount == '0);
   assign qFull  = (qCount == CntW'(DEPTH));

   // Pipeline writes are gated by reset so the GRF sees no write while reset is held.
   assign pipeOwns = Reset && Bus.P_Valid && (Bus.P_Reg != 5'd0);
   assign doPop    = Reset && !pipeOwns && !qEmpty;

   assign Bus.M_Ready = !qFull && Reset;
   // Register 0 results complete the handshake but are dropped.
   assign doPush      = Bus.M_Valid && Bus.M_Ready && (Bus.M_Reg != 5'd0);

   assign Bus.Busy_Rs   = pending[Bus.Query_Rs];
   assign Bus.Busy_Rt   = pending[Bus.Query_Rt];
   assign Bus.Stall_Req = (starveCount == 4'(STARVE_LIMIT));

   // Write-port mux: pipeline first, then queue head, otherwise idle zeros.
   always_comb begin
      Bus.RegWrite  = 1'b0;
      Bus.WriteReg  = 5'd0;
      Bus.WriteData = 32'd0;
      Bus.WPC       = 32'd0;
      if (pipeOwns) begin
         Bus.RegWrite  = 1'b1;
         Bus.WriteReg  = Bus.P_Reg;
         Bus.WriteData = Bus.P_Data;
         Bus.WPC       = Bus.P_PC;
      end else if (doPop) begin
         Bus.RegWrite  = 1'b1;
         Bus.WriteReg  = qReg[rdPtr];
         Bus.WriteData = qData[rdPtr];
         Bus.WPC       = qPc[rdPtr];
      end
   end

   // Scoreboard masks; the set mask is OR-ed last so a same-cycle set wins.
   always_comb begin
      setMask   = '0;
      clearMask = '0;
      if (Bus.Pend_Issue && (Bus.Pend_Reg != 5'd0)) setMask[Bus.Pend_Reg] = 1'b1;
      if (doPop) clearMask[qReg[rdPtr]] = 1'b1;
   end

   // Queue payload storage; contents are meaningless while the count says empty.
   always_ff @(posedge Clock) begin
      if (doPush) begin
         qReg[wrPtr]  <= Bus.M_Reg;
         qData[wrPtr] <= Bus.M_Data;
         qPc[wrPtr]   <= Bus.M_PC;
      end
   end

   // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         rdPtr  <= '0;
         wrPtr  <= '0;
         qCount <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PtrW'(1);
         if (doPop)  rdPtr <= rdPtr + PtrW'(1);
         if (doPush && !doPop)      qCount <= qCount + CntW'(1);
         else if (doPop && !doPush) qCount <= qCount - CntW'(1);
      end
   end

   // Pending bitmap of registers awaiting an MDU write-back.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) pending <= '0;
      else        pending <= (pending & ~clearMask) | setMask;
   end

   // Counts cycles the queue head loses the port to the pipeline, saturating at the limit.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         starveCount <= '0;
      end else if (doPop || qEmpty) begin
         starveCount <= '0;
      end else if (pipeOwns && (starveCount != 4'(STARVE_LIMIT))) begin
         starveCount <= starveCount + 4'd1;
      end
   end
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb/tb_grf_wb_arbiter.sv - directed vector bench for grf_wb_arbiter
module tb_grf_wb_arbiter;
   logic Clock;
   logic Reset;
   int   total;
   int   bad;
   int   contractViol;
   logic lastStall;

   grf_wb_arbiter_if bus ();

   grf_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .Bus   (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic        pV;  logic [4:0] pR;  logic [31:0] pD;  logic [31:0] pP;
      logic        mV;  logic [4:0] mR;  logic [31:0] mD;  logic [31:0] mP;
      logic        pi;  logic [4:0] pr;  logic [4:0]  qs;  logic [4:0]  qt;
      logic        eMr; logic       eRw; logic [4:0]  eWr; logic [31:0] eWd; logic [31:0] eWp;
      logic        eSt; logic       eBs; logic        eBt;
   } vec_t;

   vec_t vecs [25];

   function automatic vec_t mkV(
      input logic pV, input logic [4:0] pR, input logic [31:0] pD, input logic [31:0] pP,
      input logic mV, input logic [4:0] mR, input logic [31:0] mD, input logic [31:0] mP,
      input logic pi, input logic [4:0] pr, input logic [4:0] qs, input logic [4:0] qt,
      input logic eMr, input logic eRw, input logic [4:0] eWr, input logic [31:0] eWd,
      input logic [31:0] eWp, input logic eSt, input logic eBs, input logic eBt);
      vec_t v;
      v.pV = pV; v.pR = pR; v.pD = pD; v.pP = pP;
      v.mV = mV; v.mR = mR; v.mD = mD; v.mP = mP;
      v.pi = pi; v.pr = pr; v.qs = qs; v.qt = qt;
      v.eMr = eMr; v.eRw = eRw; v.eWr = eWr; v.eWd = eWd; v.eWp = eWp;
      v.eSt = eSt; v.eBs = eBs; v.eBt = eBt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.P_Valid = 0; bus.P_Reg = 0; bus.P_Data = 0; bus.P_PC = 0;
      bus.M_Valid = 0; bus.M_Reg = 0; bus.M_Data = 0; bus.M_PC = 0;
      bus.Pend_Issue = 0; bus.Pend_Reg = 0; bus.Query_Rs = 0; bus.Query_Rt = 0;
   endtask

   task automatic nextCycle();
      @(posedge Clock);
      #1;
   endtask

   task automatic chkPort(input string tag, input logic eRw, input logic [4:0] eWr,
                          input logic [31:0] eWd, input logic [31:0] eWp);
      chk({tag, ".RegWrite"},  32'(bus.RegWrite),  32'(eRw));
      chk({tag, ".WriteReg"},  32'(bus.WriteReg),  32'(eWr));
      chk({tag, ".WriteData"}, bus.WriteData,      eWd);
      chk({tag, ".WPC"},       bus.WPC,            eWp);
   endtask

   // Upstream must not present a pipeline write in the cycle after Stall_Req.
   always @(posedge Clock) begin
      if (Reset && lastStall && bus.P_Valid) contractViol <= contractViol + 1;
      lastStall <= Reset && bus.Stall_Req;
   end

   initial begin
      total = 0; bad = 0; contractViol = 0; lastStall = 0;

      vecs[0]  = mkV(0,0,0,0,             0,0,0,0,                 0,0,0,0,    1,0,0,0,0,                     0,0,0);
      vecs[1]  = mkV(0,0,0,0,             1,8,32'h1234,32'h3000,   0,0,0,0,    1,0,0,0,0,                     0,0,0);
      vecs[2]  = mkV(0,0,0,0,             0,0,0,0,                 0,0,0,0,    1,1,8,32'h1234,32'h3000,       0,0,0);
      vecs[3]  = mkV(0,0,0,0,             0,0,0,0,                 0,0,0,0,    1,0,0,0,0,                     0,0,0);
      vecs[4]  = mkV(1,5,32'h55,32'h100,  1,9,32'h99,32'h200,      0,0,0,0,    1,1,5,32'h55,32'h100,          0,0,0);
      vecs[5]  = mkV(0,0,0,0,             0,0,0,0,                 0,0,0,0,    1,1,9,32'h99,32'h200,          0,0,0);
      vecs[6]  = mkV(0,0,0,0,             0,0,0,0,                 0,0,0,0,    1,0,0,0,0,                     0,0,0);
      vecs[7]  = mkV(0,0,0,0,             0,0,0,0,                 1,12,12,0,  1,0,0,0,0,                     0,0,0);
      vecs[8]  = mkV(0,0,0,0,             0,0,0,0,                 0,0,12,0,   1,0,0,0,0,                     0,1,0);
      vecs[9]  = mkV(0,0,0,0,             1,12,32'hC0,32'h400,     0,0,12,0,   1,0,0,0,0,                     0,1,0);
      vecs[10] = mkV(0,0,0,0,             0,0,0,0,                 0,0,12,0,   1,1,12,32'hC0,32'h400,         0,1,0);
      vecs[11] = mkV(0,0,0,0,             0,0,0,0,                 0,0,12,0,   1,0,0,0,0,                     0,0,0);
      vecs[12] = mkV(0,0,0,0,             0,0,0,0,                 1,0,0,0,    1,0,0,0,0,                     0,0,0);
      vecs[13] = mkV(0,0,0,0,             0,0,0,0,                 0,0,0,0,    1,0,0,0,0,                     0,0,0);
      vecs[14] = mkV(0,0,0,0,             0,0,0,0,                 1,20,0,20,  1,0,0,0,0,                     0,0,0);
      vecs[15] = mkV(0,0,0,0,             0,0,0,0,                 0,0,0,20,   1,0,0,0,0,                     0,0,1);
      vecs[16] = mkV(0,0,0,0,             1,20,32'h2020,32'h600,   0,0,0,20,   1,0,0,0,0,                     0,0,1);
      vecs[17] = mkV(0,0,0,0,             0,0,0,0,                 0,0,0,20,   1,1,20,32'h2020,32'h600,       0,0,1);
      vecs[18] = mkV(0,0,0,0,             0,0,0,0,                 0,0,0,20,   1,0,0,0,0,                     0,0,0);
      vecs[19] = mkV(0,0,0,0,             1,7,32'h77,32'h500,      0,0,0,0,    1,0,0,0,0,                     0,0,0);
      vecs[20] = mkV(0,0,0,0,             0,0,0,0,                 1,7,7,0,    1,1,7,32'h77,32'h500,          0,0,0);
      vecs[21] = mkV(0,0,0,0,             0,0,0,0,                 0,0,7,0,    1,0,0,0,0,                     0,1,0);
      vecs[22] = mkV(0,0,0,0,             1,0,32'hDEAD,32'h700,    0,0,7,0,    1,0,0,0,0,                     0,1,0);
      vecs[23] = mkV(0,0,0,0,             0,0,0,0,                 0,0,7,0,    1,0,0,0,0,                     0,1,0);
      vecs[24] = mkV(1,0,32'hBEEF,32'h800, 0,0,0,0,                0,0,7,0,    1,0,0,0,0,                     0,1,0);

      // Reset state, with a pipeline write presented to prove it is gated.
      Reset = 0;
      idle();
      bus.P_Valid = 1; bus.P_Reg = 4; bus.P_Data = 32'h44; bus.Query_Rs = 4;
      nextCycle();
      nextCycle();
      chk("rst.RegWrite",  32'(bus.RegWrite),  0);
      chk("rst.M_Ready",   32'(bus.M_Ready),   0);
      chk("rst.Stall_Req", 32'(bus.Stall_Req), 0);
      chk("rst.Busy_Rs",   32'(bus.Busy_Rs),   0);
      chk("rst.Busy_Rt",   32'(bus.Busy_Rt),   0);
      Reset = 1;

      for (int i = 0; i < 25; i++) begin
         bus.P_Valid = vecs[i].pV; bus.P_Reg = vecs[i].pR; bus.P_Data = vecs[i].pD; bus.P_PC = vecs[i].pP;
         bus.M_Valid = vecs[i].mV; bus.M_Reg = vecs[i].mR; bus.M_Data = vecs[i].mD; bus.M_PC = vecs[i].mP;
         bus.Pend_Issue = vecs[i].pi; bus.Pend_Reg = vecs[i].pr;
         bus.Query_Rs = vecs[i].qs; bus.Query_Rt = vecs[i].qt;
         @(negedge Clock);
         chk($sformatf("v%0d.M_Ready", i),   32'(bus.M_Ready),   32'(vecs[i].eMr));
         chkPort($sformatf("v%0d", i), vecs[i].eRw, vecs[i].eWr, vecs[i].eWd, vecs[i].eWp);
         chk($sformatf("v%0d.Stall_Req", i), 32'(bus.Stall_Req), 32'(vecs[i].eSt));
         chk($sformatf("v%0d.Busy_Rs", i),   32'(bus.Busy_Rs),   32'(vecs[i].eBs));
         chk($sformatf("v%0d.Busy_Rt", i),   32'(bus.Busy_Rt),   32'(vecs[i].eBt));
         nextCycle();
      end

      // Starvation: pipeline holds the port while three MDU results arrive.
      idle();
      bus.P_Valid = 1; bus.P_Reg = 3; bus.P_Data = 32'h33; bus.P_PC = 32'h330;
      bus.M_Valid = 1; bus.M_Reg = 10; bus.M_Data = 32'hA0; bus.M_PC = 32'hA00;
      #2;
      chk("st.a.M_Ready", 32'(bus.M_Ready), 1);
      chkPort("st.a", 1, 3, 32'h33, 32'h330);
      nextCycle();
      bus.M_Reg = 11; bus.M_Data = 32'hB0; bus.M_PC = 32'hB00;
      #2;
      chk("st.b.M_Ready", 32'(bus.M_Ready), 1);
      chk("st.b.Stall_Req", 32'(bus.Stall_Req), 0);
      nextCycle();
      bus.M_Reg = 13; bus.M_Data = 32'hD0; bus.M_PC = 32'hD00;
      #2;
      chk("st.c.M_Ready", 32'(bus.M_Ready), 0);
      chk("st.c.Stall_Req", 32'(bus.Stall_Req), 0);
      nextCycle();
      #2;
      chk("st.d.Stall_Req", 32'(bus.Stall_Req), 0);
      nextCycle();
      #2;
      chk("st.e.Stall_Req", 32'(bus.Stall_Req), 0);
      nextCycle();
      #2;
      chk("st.f.Stall_Req", 32'(bus.Stall_Req), 1);
      chkPort("st.f", 1, 3, 32'h33, 32'h330);
      nextCycle();
      bus.P_Valid = 0;
      #2;
      chk("st.g.Stall_Req", 32'(bus.Stall_Req), 1);
      chk("st.g.M_Ready", 32'(bus.M_Ready), 0);
      chkPort("st.g", 1, 10, 32'hA0, 32'hA00);
      nextCycle();
      #2;
      chk("st.h.Stall_Req", 32'(bus.Stall_Req), 0);
      chk("st.h.M_Ready", 32'(bus.M_Ready), 1);
      chkPort("st.h", 1, 11, 32'hB0, 32'hB00);
      nextCycle();
      bus.M_Valid = 0;
      #2;
      chkPort("st.i", 1, 13, 32'hD0, 32'hD00);
      nextCycle();
      #2;
      chkPort("st.j", 0, 0, 0, 0);
      nextCycle();

      // Reset mid-operation with a full queue and pending bits.
      idle();
      bus.P_Valid = 1; bus.P_Reg = 2; bus.P_Data = 32'h22; bus.P_PC = 32'h900;
      bus.M_Valid = 1; bus.M_Reg = 14; bus.M_Data = 32'hE0; bus.M_PC = 32'hA00;
      bus.Pend_Issue = 1; bus.Pend_Reg = 15;
      #2;
      chk("rm.a.M_Ready", 32'(bus.M_Ready), 1);
      nextCycle();
      bus.M_Reg = 16; bus.M_Data = 32'h160; bus.Pend_Reg = 17;
      #2;
      chk("rm.b.M_Ready", 32'(bus.M_Ready), 1);
      nextCycle();
      bus.M_Valid = 0; bus.Pend_Issue = 0; bus.Query_Rs = 15; bus.Query_Rt = 17;
      #2;
      chk("rm.c.M_Ready", 32'(bus.M_Ready), 0);
      chk("rm.c.Busy_Rs", 32'(bus.Busy_Rs), 1);
      chk("rm.c.Busy_Rt", 32'(bus.Busy_Rt), 1);
      chkPort("rm.c", 1, 2, 32'h22, 32'h900);
      Reset = 0;
      #1;
      chk("rm.d.RegWrite", 32'(bus.RegWrite), 0);
      chk("rm.d.M_Ready",  32'(bus.M_Ready),  0);
      chk("rm.d.Busy_Rs",  32'(bus.Busy_Rs),  0);
      chk("rm.d.Busy_Rt",  32'(bus.Busy_Rt),  0);
      chk("rm.d.Stall_Req", 32'(bus.Stall_Req), 0);
      nextCycle();
      chk("rm.e.M_Ready", 32'(bus.M_Ready), 0);
      idle();
      bus.Query_Rs = 15; bus.Query_Rt = 7;
      Reset = 1;
      #2;
      chk("rm.f.M_Ready", 32'(bus.M_Ready), 1);
      chk("rm.f.Busy_Rs", 32'(bus.Busy_Rs), 0);
      chk("rm.f.Busy_Rt", 32'(bus.Busy_Rt), 0);
      chkPort("rm.f", 0, 0, 0, 0);
      nextCycle();
      #2;
      chk("rm.g.M_Ready", 32'(bus.M_Ready), 1);
      chkPort("rm.g", 0, 0, 0, 0);
      nextCycle();

      chk("contract_stall", 32'(contractViol), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
